cpu_bus_arbiter: RTL and testbench

CPU_BUS_ARBITER -- requirements
Module: cpu_bus_arbiter

---
 rtl/cpu_bus_pkg.sv | 20 ++
 rtl/cpu_bus_if.sv | 39 +++
 rtl/oam_dma_engine.sv | 83 ++++++++
 rtl/cpu_bus_arbiter.sv | 99 +++++++++
 tb/tb_cpu_bus_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared encodings for the CPU bus arbiter and its OAM DMA sequencer.
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        GRANT_IE  = 2'b00,
        GRANT_IH  = 2'b01,
        GRANT_DMA = 2'b10
    } grant_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ALIGN = 2'b01,
        READ  = 2'b10,
        WRITE = 2'b11
    } dma_state_t;

    localparam logic [15:0] OAMDMA_ADDR  = 16'h4014;
    localparam logic [15:0] OAMDATA_ADDR = 16'h2004;

endpackage

// File: rtl/cpu_bus_if.sv
// Requester and memory side signals of the shared CPU bus.
interface cpu_bus_if;

    logic [15:0] ie_addr;
    logic [7:0]  ie_data_out;
    logic        ie_write_en;
    logic [7:0]  ie_data_in;
    logic        ie_stall;

    logic [15:0] ih_addr;
    logic [7:0]  ih_data_out;
    logic        ih_write_en;
    logic        ih_busy;
    logic [7:0]  ih_data_in;

    logic [15:0] mem_addr;
    logic [7:0]  mem_data_out;
    logic        mem_write_en;
    logic [7:0]  mem_data_in;

    modport slave (
        input  ie_addr, ie_data_out, ie_write_en,
        output ie_data_in, ie_stall,
        input  ih_addr, ih_data_out, ih_write_en, ih_busy,
        output ih_data_in,
        output mem_addr, mem_data_out, mem_write_en,
        input  mem_data_in
    );

    modport master (
        output ie_addr, ie_data_out, ie_write_en,
        input  ie_data_in, ie_stall,
        output ih_addr, ih_data_out, ih_write_en, ih_busy,
        input  ih_data_in,
        input  mem_addr, mem_data_out, mem_write_en,
        output mem_data_in
    );

endinterface

// File: rtl/oam_dma_engine.sv
// OAM DMA sequencer: even-cycle alignment, then 256 read/write pairs
// from {page,cnt} into the OAM data port.
module oam_dma_engine
    import cpu_bus_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] start_page,
    output dma_state_t state,
    output logic [7:0] cnt,
    output logic [7:0] page,
    output logic       dma_done
);

    dma_state_t state_d, state_q;
    logic [7:0] cnt_d, cnt_q;
    logic [7:0] page_d, page_q;
    logic       cycle_odd_d, cycle_odd_q;
    logic       dma_done_d, dma_done_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        page_d      = page_q;
        cycle_odd_d = ~cycle_odd_q;
        dma_done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ALIGN;
                    cnt_d   = '0;
                    page_d  = start_page;
                end
            end
            // Leaving on an odd cycle guarantees READ lands on an even one.
            ALIGN: begin
                if (cycle_odd_q) begin
                    state_d = READ;
                end
            end
            READ: begin
                state_d = WRITE;
            end
            WRITE: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'hFF) begin
                    state_d    = IDLE;
                    dma_done_d = 1'b1;
                end else begin
                    state_d = READ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            page_q      <= '0;
            cycle_odd_q <= 1'b0;
            dma_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            page_q      <= page_d;
            cycle_odd_q <= cycle_odd_d;
            dma_done_q  <= dma_done_d;
        end
    end

    always_comb begin
        state    = state_q;
        cnt      = cnt_q;
        page     = page_q;
        dma_done = dma_done_q;
    end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Shared memory bus arbiter: DMA over interrupt handler over instruction
// engine, with an OAM DMA triggered by IE writes to $4014.
module cpu_bus_arbiter
    import cpu_bus_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    cpu_bus_if.slave   bus,
    output logic [1:0] grant,
    output logic       dma_active,
    output logic       dma_done,
    output logic       arb_conflict
);

    dma_state_t dma_state;
    logic [7:0] dma_cnt;
    logic [7:0] dma_page;
    grant_t     grant_sel;
    logic       dma_start;
    logic       arb_conflict_d, arb_conflict_q;

    always_comb begin
        if (dma_state != IDLE) begin
            grant_sel = GRANT_DMA;
        end else if (bus.ih_busy) begin
            grant_sel = GRANT_IH;
        end else begin
            grant_sel = GRANT_IE;
        end
        dma_start = (grant_sel == GRANT_IE) && bus.ie_write_en &&
                    (bus.ie_addr == OAMDMA_ADDR);
    end

    oam_dma_engine u_dma (
        .clk        (clk),
        .rst        (rst),
        .start      (dma_start),
        .start_page (bus.ie_data_out),
        .state      (dma_state),
        .cnt        (dma_cnt),
        .page       (dma_page),
        .dma_done   (dma_done)
    );

    always_comb begin
        bus.mem_addr     = bus.ie_addr;
        bus.mem_data_out = bus.ie_data_out;
        bus.mem_write_en = bus.ie_write_en;
        case (grant_sel)
            GRANT_DMA: begin
                bus.mem_data_out = '0;
                bus.mem_write_en = 1'b0;
                case (dma_state)
                    READ: begin
                        bus.mem_addr = {dma_page, dma_cnt};
                    end
                    // Registered read data from the previous READ goes straight back out.
                    WRITE: begin
                        bus.mem_addr     = OAMDATA_ADDR;
                        bus.mem_data_out = bus.mem_data_in;
                        bus.mem_write_en = 1'b1;
                    end
                    default: begin
                        bus.mem_addr = '0;
                    end
                endcase
            end
            GRANT_IH: begin
                bus.mem_addr     = bus.ih_addr;
                bus.mem_data_out = bus.ih_data_out;
                bus.mem_write_en = bus.ih_write_en;
            end
            default: begin
                bus.mem_addr     = bus.ie_addr;
                bus.mem_data_out = bus.ie_data_out;
                bus.mem_write_en = bus.ie_write_en;
            end
        endcase
    end

    always_comb begin
        bus.ie_data_in = bus.mem_data_in;
        bus.ih_data_in = bus.mem_data_in;
        bus.ie_stall   = (grant_sel != GRANT_IE);
        grant          = grant_sel;
        dma_active     = (dma_state != IDLE);
        arb_conflict_d = arb_conflict_q | (dma_active & bus.ih_busy);
        arb_conflict   = arb_conflict_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arb_conflict_q <= 1'b0;
        end else begin
            arb_conflict_q <= arb_conflict_d;
        end
    end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Self-checking bench for cpu_bus_arbiter against a cycle-indexed DMA model.
module tb_cpu_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] grant;
    logic       dma_active;
    logic       dma_done;
    logic       arb_conflict;

    cpu_bus_if bus ();

    cpu_bus_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .grant        (grant),
        .dma_active   (dma_active),
        .dma_done     (dma_done),
        .arb_conflict (arb_conflict)
    );

    always #5 clk = ~clk;

    // Registered-read memory.
    logic [7:0] mem [0:65535];
    always @(posedge clk) begin
        if (bus.mem_write_en) mem[bus.mem_addr] <= bus.mem_data_out;
        bus.mem_data_in <= mem[bus.mem_addr];
    end

    // Model: DMA described by cycle index k since the first ALIGN cycle.
    int         m_cyc = 0;
    int         m_k = -1;
    int         m_align = 0;
    logic [7:0] m_page = '0;
    logic       m_conflict = 1'b0;
    logic       m_done = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cyc      <= 0;
            m_k        <= -1;
            m_align    <= 0;
            m_page     <= '0;
            m_conflict <= 1'b0;
            m_done     <= 1'b0;
        end else begin
            m_cyc  <= m_cyc + 1;
            m_done <= (m_k >= 0) && (m_k == m_align + 511);
            if (m_k >= 0 && bus.ih_busy) m_conflict <= 1'b1;
            if (m_k >= 0) begin
                m_k <= (m_k == m_align + 511) ? -1 : m_k + 1;
            end else if (!bus.ih_busy && bus.ie_write_en && bus.ie_addr == 16'h4014) begin
                m_k     <= 0;
                m_page  <= bus.ie_data_out;
                m_align <= (((m_cyc + 1) % 2) == 1) ? 1 : 2;
            end
        end
    end

    int         checks = 0;
    int         errors = 0;
    int         act_cnt = 0;
    int         done_cnt = 0;
    int         stall_bad = 0;
    int         rd0_cnt = 0;
    int         rd0_par = 0;
    logic [7:0] wq [$];
    logic [7:0] exp_page [0:255];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare();
        logic [1:0]  eg;
        logic [15:0] ea;
        logic        ew;
        logic [7:0]  ed;
        int          j;
        ed = '0;
        if (m_k >= 0) begin
            eg = 2'd2;
            if (m_k < m_align) begin
                ea = 16'h0000;
                ew = 1'b0;
            end else begin
                j = m_k - m_align;
                if (j % 2 == 0) begin
                    ea = {m_page, 8'(j / 2)};
                    ew = 1'b0;
                end else begin
                    ea = 16'h2004;
                    ew = 1'b1;
                    ed = mem[{m_page, 8'(j / 2)}];
                end
            end
        end else if (bus.ih_busy) begin
            eg = 2'd1;
            ea = bus.ih_addr;
            ew = bus.ih_write_en;
            ed = bus.ih_data_out;
        end else begin
            eg = 2'd0;
            ea = bus.ie_addr;
            ew = bus.ie_write_en;
            ed = bus.ie_data_out;
        end
        chk("grant", 32'(grant), 32'(eg));
        chk("ie_stall", 32'(bus.ie_stall), 32'(eg != 2'd0));
        chk("mem_addr", 32'(bus.mem_addr), 32'(ea));
        chk("mem_write_en", 32'(bus.mem_write_en), 32'(ew));
        if (ew) chk("mem_data_out", 32'(bus.mem_data_out), 32'(ed));
        chk("dma_active", 32'(dma_active), 32'(m_k >= 0));
        chk("dma_done", 32'(dma_done), 32'(m_done));
        chk("arb_conflict", 32'(arb_conflict), 32'(m_conflict));
        chk("ie_data_in", 32'(bus.ie_data_in), 32'(bus.mem_data_in));
        chk("ih_data_in", 32'(bus.ih_data_in), 32'(bus.mem_data_in));
        if (dma_active) act_cnt++;
        if (dma_done) done_cnt++;
        if (dma_active && !bus.ie_stall) stall_bad++;
        if (grant == 2'd2 && bus.mem_write_en && bus.mem_addr == 16'h2004)
            wq.push_back(bus.mem_data_out);
        if (grant == 2'd2 && !bus.mem_write_en && bus.mem_addr != 16'h0000 &&
            bus.mem_addr[7:0] == 8'h00) begin
            rd0_cnt++;
            rd0_par = m_cyc % 2;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
        @(posedge clk);
        #2;
    endtask

    task automatic preload(input logic [7:0] pg, input bit xor_pattern);
        for (int i = 0; i < 256; i++) begin
            bus.ih_busy     = 1'b0;
            bus.ie_addr     = {pg, 8'(i)};
            exp_page[i]     = xor_pattern ? (8'(i) ^ 8'hA5) : 8'($urandom);
            bus.ie_data_out = exp_page[i];
            bus.ie_write_en = 1'b1;
            tick();
        end
        bus.ie_write_en = 1'b0;
        bus.ie_addr     = 16'h0000;
    endtask

    task automatic run_dma(input logic [7:0] pg, input bit align_odd, input bit pulse_conflict);
        int  b_act, b_done, b_wq, b_stall, b_rd0, exp_len;
        bit  pulsed;
        pulsed = 1'b0;
        bus.ih_busy     = 1'b0;
        bus.ih_write_en = 1'b0;
        // The ALIGN cycle's parity is one past the current cycle's.
        if (((m_cyc % 2) == 0) != align_odd) tick();
        b_act   = act_cnt;
        b_done  = done_cnt;
        b_wq    = wq.size();
        b_stall = stall_bad;
        b_rd0   = rd0_cnt;
        bus.ie_addr     = 16'h4014;
        bus.ie_data_out = pg;
        bus.ie_write_en = 1'b1;
        tick();
        bus.ie_write_en = 1'b0;
        bus.ie_addr     = 16'h4014;
        for (int n = 0; n < 700 && !(done_cnt > b_done); n++) begin
            if (pulse_conflict && !pulsed && grant == 2'd2 && !bus.mem_write_en &&
                bus.mem_addr == {pg, 8'h10}) begin
                tick();
                bus.ih_busy = 1'b1;
                tick();
                bus.ih_busy = 1'b0;
                pulsed = 1'b1;
            end else begin
                tick();
            end
        end
        chk("dma_done_seen", 32'(done_cnt > b_done), 32'd1);
        for (int n = 0; n < 3; n++) tick();
        exp_len = align_odd ? 513 : 514;
        chk("dma_length", 32'(act_cnt - b_act), 32'(exp_len));
        chk("dma_done_pulses", 32'(done_cnt - b_done), 32'd1);
        chk("write_count", 32'(wq.size() - b_wq), 32'd256);
        for (int i = 0; i < 256 && b_wq + i < wq.size(); i++)
            chk($sformatf("oam_byte_%0d", i), 32'(wq[b_wq + i]), 32'(exp_page[i]));
        chk("stall_during_dma", 32'(stall_bad - b_stall), 32'd0);
        chk("first_read_count", 32'(rd0_cnt - b_rd0), 32'd1);
        chk("first_read_even", 32'(rd0_par), 32'd0);
        chk("grant_after_dma", 32'(grant), 32'd0);
        if (pulse_conflict) chk("conflict_sticky", 32'(arb_conflict), 32'd1);
    endtask

    initial begin
        int b_wq;
        bit found;
        bus.ie_addr     = '0;
        bus.ie_data_out = '0;
        bus.ie_write_en = 1'b0;
        bus.ih_addr     = '0;
        bus.ih_data_out = '0;
        bus.ih_write_en = 1'b0;
        bus.ih_busy     = 1'b0;
        #1 rst = 1'b1;
        for (int n = 0; n < 3; n++) tick();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_dma_active", 32'(dma_active), 32'd0);
        chk("rst_dma_done", 32'(dma_done), 32'd0);
        chk("rst_conflict", 32'(arb_conflict), 32'd0);
        rst = 1'b0;
        tick();

        bus.ie_addr = 16'h1234;
        #1;
        chk("idle_grant_ie", 32'(grant), 32'd0);
        chk("idle_addr_ie", 32'(bus.mem_addr), 32'h1234);
        bus.ih_busy = 1'b1;
        bus.ih_addr = 16'hFFFA;
        #1;
        chk("idle_grant_ih", 32'(grant), 32'd1);
        chk("idle_addr_ih", 32'(bus.mem_addr), 32'hFFFA);
        chk("idle_stall_ih", 32'(bus.ie_stall), 32'd1);
        tick();

        for (int n = 0; n < 300; n++) begin
            bus.ie_addr     = 16'($urandom);
            bus.ie_data_out = 8'($urandom);
            bus.ie_write_en = 1'($urandom);
            if (bus.ie_addr == 16'h4014) bus.ie_addr = 16'h4015;
            bus.ih_busy     = ($urandom_range(0, 2) == 0);
            bus.ih_addr     = (n % 50 == 7) ? 16'h4014 : 16'($urandom);
            bus.ih_data_out = 8'($urandom);
            bus.ih_write_en = 1'($urandom);
            tick();
        end
        bus.ih_busy     = 1'b1;
        bus.ih_write_en = 1'b1;
        bus.ih_addr     = 16'h4014;
        bus.ie_addr     = 16'h4014;
        bus.ie_write_en = 1'b1;
        tick();
        bus.ih_busy     = 1'b0;
        bus.ih_write_en = 1'b0;
        bus.ie_write_en = 1'b0;
        bus.ie_addr     = 16'h0000;
        tick();
        chk("ih_4014_no_dma", 32'(dma_active), 32'd0);

        preload(8'h02, 1'b0);
        run_dma(8'h02, 1'b1, 1'b0);
        run_dma(8'h02, 1'b0, 1'b0);
        preload(8'h07, 1'b1);
        for (int i = 0; i < 256; i++)
            chk("xor_pattern_pin", 32'(exp_page[i]), 32'(8'(i) ^ 8'hA5));
        run_dma(8'h07, 1'b1, 1'b0);
        run_dma(8'h07, 1'b0, 1'b1);

        // Abort mid-transfer with an asynchronous reset.
        bus.ie_addr     = 16'h4014;
        bus.ie_data_out = 8'h07;
        bus.ie_write_en = 1'b1;
        tick();
        bus.ie_write_en = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 400 && !found; n++) begin
            if (grant == 2'd2 && !bus.mem_write_en && bus.mem_addr == 16'h0780) found = 1'b1;
            else tick();
        end
        chk("reached_cnt_80", 32'(found), 32'd1);
        b_wq = wq.size();
        rst = 1'b1;
        #1;
        chk("abort_dma_active", 32'(dma_active), 32'd0);
        chk("abort_grant", 32'(grant), 32'd0);
        chk("abort_write_en", 32'(bus.mem_write_en), 32'd0);
        chk("abort_conflict_cleared", 32'(arb_conflict), 32'd0);
        tick();
        tick();
        bus.ih_busy = 1'b1;
        bus.ie_addr = 16'h0000;
        rst = 1'b0;
        tick();
        #1;
        chk("post_reset_grant_ih", 32'(grant), 32'd1);
        chk("post_reset_no_write", 32'(bus.mem_write_en), 32'd0);
        bus.ih_busy = 1'b0;
        for (int n = 0; n < 20; n++) tick();
        chk("no_writes_after_abort", 32'(wq.size() - b_wq), 32'd0);
        chk("idle_after_abort", 32'(dma_active), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
